// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage.
//   F3_*         : funct3 encodings for load/store width and sign
//   mem_state_e  : data-memory handshake FSM states
//   illegal_f3() : true for funct3 values that are not a valid load/store width
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  function automatic logic illegal_f3(input logic [2:0] f3);
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load/store lane alignment (purely combinational).
//   funct3_i    : access width / sign
//   offset_i    : addr[1:0] of the effective address
//   store_data_i: rs2 value to be stored
//   rdata_i     : word returned by data memory
//   wstrb_o     : byte enables for a store at this offset
//   wdata_o     : store data replicated across all lanes
//   load_data_o : selected and sign/zero-extended load result
//   misalign_o  : address not aligned to the width, or funct3 illegal
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    wstrb_o     = 4'b0000;
    wdata_o     = store_data_i;
    load_data_o = 32'h0;
    misalign_o  = 1'b0;
    if (illegal_f3(funct3_i)) begin
      misalign_o = 1'b1;
    end else begin
      case (funct3_i[1:0])
        2'b00: begin
          wstrb_o     = 4'b0001 << offset_i;
          wdata_o     = {4{store_data_i[7:0]}};
          load_data_o = {{24{byte_sel[7] & ~funct3_i[2]}}, byte_sel};
        end
        2'b01: begin
          misalign_o  = offset_i[0];
          wstrb_o     = 4'b0011 << {offset_i[1], 1'b0};
          wdata_o     = {2{store_data_i[15:0]}};
          load_data_o = {{16{half_sel[15] & ~funct3_i[2]}}, half_sel};
        end
        default: begin
          misalign_o  = |offset_i;
          wstrb_o     = 4'b1111;
          load_data_o = rdata_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM and MEM/WB pipeline registers plus the
// data-memory req/ack handshake with timeout.
//   clk, rst                 : clock, asynchronous active-high reset
//   ex_*                     : instruction fields arriving from ex_stage
//   dmem_req/we/addr/wdata/wstrb, dmem_ack/rdata : data-memory port
//   mem_stall                : freezes the upstream pipeline while an access waits
//   exmem_*                  : EX/MEM register contents for forwarding
//   wb_wdata/wb_rd/wb_regwrite : MEM/WB register contents
//   mem_misalign, mem_timeout  : one-cycle fault pulses
module mem_stage
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_memtoreg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] exmem_alu_result,
  output logic [4:0]  exmem_rd,
  output logic        exmem_regwrite,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        mem_misalign,
  output logic        mem_timeout
);

  // EX/MEM register
  logic [31:0] alu_q, sdata_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic        rw_q, mr_q, mw_q, mtr_q;

  // MEM/WB register
  logic [31:0] wb_wdata_q;
  logic [4:0]  wb_rd_q;
  logic        wb_rw_q;

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        store, load, memop, bad_op, good_op, timeout_hit;
  logic [3:0]  lsu_wstrb;
  logic [31:0] lsu_wdata, lsu_load;
  logic        lsu_misalign;

  assign store   = mw_q;
  assign load    = mr_q & ~mw_q;
  assign memop   = load | store;
  assign bad_op  = memop & lsu_misalign;
  assign good_op = memop & ~lsu_misalign;

  lsu_align u_lsu_align (
    .funct3_i     (f3_q),
    .offset_i     (alu_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (dmem_rdata),
    .wstrb_o      (lsu_wstrb),
    .wdata_o      (lsu_wdata),
    .load_data_o  (lsu_load),
    .misalign_o   (lsu_misalign)
  );

  // The IDLE cycle already counts as one request cycle, so the counter
  // (0 in the first WAIT cycle) hits when its incremented value would
  // reach TIMEOUT-1; dmem_req is then high for exactly TIMEOUT cycles.
  assign timeout_hit = (state_q == MEM_WAIT) & ~dmem_ack &
                       (cnt_q == CNT_W'(TIMEOUT - 2));

  assign dmem_req     = good_op & ~rst;
  assign dmem_we      = store;
  assign dmem_addr    = {alu_q[31:2], 2'b00};
  assign dmem_wdata   = lsu_wdata;
  assign dmem_wstrb   = store ? lsu_wstrb : 4'b0000;
  assign mem_stall    = dmem_req & ~dmem_ack & ~timeout_hit;
  assign mem_misalign = bad_op & ~rst;
  assign mem_timeout  = timeout_hit & ~rst;

  assign exmem_alu_result = alu_q;
  assign exmem_rd         = rd_q;
  assign exmem_regwrite   = rw_q;
  assign wb_wdata         = wb_wdata_q;
  assign wb_rd            = wb_rd_q;
  assign wb_regwrite      = wb_rw_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MEM_IDLE: begin
        if (good_op && !dmem_ack) begin
          state_d = MEM_WAIT;
          cnt_d   = '0;
        end
      end
      MEM_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_ack || timeout_hit) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= '0;
      sdata_q <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      mtr_q   <= 1'b0;
    end else if (!mem_stall) begin
      alu_q   <= ex_alu_result;
      sdata_q <= ex_store_data;
      rd_q    <= ex_rd;
      f3_q    <= ex_funct3;
      rw_q    <= ex_regwrite;
      mr_q    <= ex_memread;
      mw_q    <= ex_memwrite;
      mtr_q   <= ex_memtoreg;
    end
  end

  // While stalled, MEM/WB fills with bubbles; a faulted access retires
  // without writing the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wdata_q <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
    end else if (mem_stall) begin
      wb_wdata_q <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
    end else begin
      wb_wdata_q <= mtr_q ? lsu_load : alu_q;
      wb_rd_q    <= rd_q;
      wb_rw_q    <= rw_q & ~bad_op & ~timeout_hit;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ex_alu_result = '0, ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_regwrite = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0, ex_memtoreg = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_stall;
  logic [31:0] exmem_alu_result;
  logic [4:0]  exmem_rd;
  logic        exmem_regwrite;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        mem_misalign, mem_timeout;

  mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .exmem_alu_result(exmem_alu_result), .exmem_rd(exmem_rd),
    .exmem_regwrite(exmem_regwrite),
    .wb_wdata(wb_wdata), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_misalign(mem_misalign), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle handshake/forwarding outputs, tagged with the
  // number of the clock edge that ends that cycle.
  typedef struct {
    int          tag;
    logic        req, stall, mis, tmo, we;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [31:0] ex_alu;
    logic [4:0]  ex_rd;
    logic        ex_rw;
  } ctl_t;

  // Expected MEM/WB contents, tagged with the edge that captures them.
  typedef struct {
    int          tag;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        chk_wd;
  } wb_t;

  ctl_t ctl_q[$];
  wb_t  wb_q[$];
  ctl_t mon_c;
  wb_t  mon_w;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (checking) begin
      while (ctl_q.size() > 0 && ctl_q[0].tag < cyc + 1) begin
        chk("ctl_missed", 32'(ctl_q[0].tag), 32'(cyc + 1));
        void'(ctl_q.pop_front());
      end
      if (ctl_q.size() > 0 && ctl_q[0].tag == cyc + 1) begin
        mon_c = ctl_q.pop_front();
        chk("dmem_req", 32'(dmem_req), 32'(mon_c.req));
        chk("mem_stall", 32'(mem_stall), 32'(mon_c.stall));
        chk("mem_misalign", 32'(mem_misalign), 32'(mon_c.mis));
        chk("mem_timeout", 32'(mem_timeout), 32'(mon_c.tmo));
        chk("exmem_alu_result", exmem_alu_result, mon_c.ex_alu);
        chk("exmem_rd", 32'(exmem_rd), 32'(mon_c.ex_rd));
        chk("exmem_regwrite", 32'(exmem_regwrite), 32'(mon_c.ex_rw));
        if (mon_c.req) begin
          chk("dmem_we", 32'(dmem_we), 32'(mon_c.we));
          chk("dmem_addr", dmem_addr, mon_c.addr);
          chk("dmem_wstrb", 32'(dmem_wstrb), 32'(mon_c.strb));
          if (mon_c.we) chk("dmem_wdata", dmem_wdata, mon_c.wdata);
        end
      end
      while (wb_q.size() > 0 && wb_q[0].tag < cyc) begin
        chk("wb_missed", 32'(wb_q[0].tag), 32'(cyc));
        void'(wb_q.pop_front());
      end
      if (wb_q.size() > 0 && wb_q[0].tag == cyc) begin
        mon_w = wb_q.pop_front();
        chk("wb_regwrite", 32'(wb_regwrite), 32'(mon_w.rw));
        chk("wb_rd", 32'(wb_rd), 32'(mon_w.rd));
        if (mon_w.chk_wd) chk("wb_wdata", wb_wdata, mon_w.wd);
      end
    end
  end

  // Reference: a load returns the sz-byte field starting at byte offset o,
  // sign-extended unless funct3[2] is set.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int o,
                                             input logic [31:0] rdata);
    int          sz;
    logic [31:0] sh, mask, v;
    sz   = 1 << f3[1:0];
    sh   = rdata >> (8 * o);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = sh & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // Issue one instruction, push its expected behaviour, then play the
  // memory side: ack arrives lat cycles after the request (lat<0 or
  // lat>=TO: never). Returns at the negedge of the instruction's last cycle.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic [2:0] f3,
                       input logic rw, input logic mr, input logic mw,
                       input int lat, input logic [31:0] rdata);
    int          e0, sz, o, r;
    logic        store, load, memop, legal, bad, good, acked;
    logic [3:0]  strb;
    logic [31:0] wd;
    ctl_t        c;
    wb_t         w;
    ex_alu_result = alu;  ex_store_data = sdata; ex_rd = rd; ex_funct3 = f3;
    ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw; ex_memtoreg = mr & ~mw;
    $display("txn: mr=%0d mw=%0d f3=%0d addr=%h sdata=%h rd=%0d rw=%0d lat=%0d",
             mr, mw, f3, alu, sdata, rd, rw, lat);
    @(posedge clk);
    #1;
    e0 = cyc;
    dmem_ack = 1'b0;
    dmem_rdata = rdata;

    store = mw;
    load  = mr & ~mw;
    memop = store | load;
    sz    = 1 << f3[1:0];
    o     = int'(alu[1:0]);
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    bad   = memop && (!legal || (o % sz) != 0);
    good  = memop && !bad;
    acked = (lat >= 0 && lat <= TO - 1);
    r     = !good ? 1 : (acked ? lat + 1 : TO);
    for (int i = 0; i < 4; i++) begin
      strb[i] = (i >= o && i < o + sz);
      wd[8*i +: 8] = sdata[8*(i % sz) +: 8];
    end

    for (int k = 0; k < r; k++) begin
      c.tag = e0 + 1 + k;
      c.req = good;
      c.stall = good && (k < r - 1);
      c.mis = bad;
      c.tmo = good && !acked && (k == r - 1);
      c.we = store;
      c.addr = {alu[31:2], 2'b00};
      c.wdata = wd;
      c.strb = store ? strb : 4'b0000;
      c.ex_alu = alu; c.ex_rd = rd; c.ex_rw = rw;
      ctl_q.push_back(c);
      w.tag = e0 + 1 + k;
      if (k < r - 1) begin
        w.rw = 1'b0; w.rd = 5'd0; w.wd = 32'd0; w.chk_wd = 1'b1;
      end else begin
        w.rw = rw && !bad && !(good && !acked);
        w.rd = rd;
        w.wd = load ? model_load(f3, o, rdata) : alu;
        w.chk_wd = w.rw;
      end
      wb_q.push_back(w);
    end

    for (int k = 0; k < r; k++) begin
      @(negedge clk);
      dmem_ack = good && acked && (k == lat);
      if (k < r - 1) begin
        // EX/MEM must ignore whatever ex_stage shows while stalled
        ex_alu_result = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom);
        ex_funct3 = 3'($urandom); ex_regwrite = 1'($urandom);
        ex_memread = 1'($urandom); ex_memwrite = 1'($urandom); ex_memtoreg = 1'($urandom);
        @(posedge clk);
        #1 dmem_ack = 1'b0;
      end
    end
  endtask

  task automatic issue_random();
    int          kind, sel, lat;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic        mr, mw;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    kind = $urandom_range(0, 9);
    mr = (kind >= 3 && kind <= 5) || kind == 9;
    mw = kind >= 6;
    f3 = ($urandom_range(0, 99) < 85) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
    alu = $urandom;
    if ($urandom_range(0, 9) < 7) alu[1:0] = alu[1:0] & ~2'((1 << f3[1:0]) - 1);
    sel = $urandom_range(0, 19);
    if (sel < 8)        lat = 0;
    else if (sel < 17)  lat = $urandom_range(1, 5);
    else if (sel == 17) lat = TO - 1;
    else                lat = -1;
    issue(alu, $urandom, 5'($urandom), f3, 1'($urandom), mr, mw, lat, $urandom);
  endtask

  initial begin
    // Reset: drive a live load at the inputs; nothing may leak out.
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3; ex_alu_result = 32'h40;
    ex_funct3 = 3'd2; ex_memtoreg = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_exmem_rd", 32'(exmem_rd), 32'd0);
    chk("rst_exmem_alu", exmem_alu_result, 32'd0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_pulses", 32'({mem_misalign, mem_timeout}), 32'd0);
    chk("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // Directed cases
    issue(32'h100, 32'hDEADBEEF, 5'd0, 3'd2, 1'b0, 1'b0, 1'b1, 0, 32'h0);    // SW
    issue(32'h103, 32'h000000AB, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 0, 32'h0);    // SB
    issue(32'h103, 32'h0, 5'd5, 3'd0, 1'b1, 1'b1, 1'b0, 0, 32'hAB000000);    // LB
    issue(32'h103, 32'h0, 5'd6, 3'd4, 1'b1, 1'b1, 1'b0, 0, 32'hAB000000);    // LBU
    issue(32'h102, 32'h0, 5'd7, 3'd1, 1'b1, 1'b1, 1'b0, 3, 32'h80010000);    // LH, 3 waits
    issue(32'h101, 32'h0, 5'd8, 3'd2, 1'b1, 1'b1, 1'b0, 0, 32'h12345678);    // LW misaligned
    issue(32'h200, 32'h0, 5'd9, 3'd2, 1'b1, 1'b1, 1'b0, -1, 32'h0);          // LW timeout
    issue(32'h1234, 32'h0, 5'd10, 3'd0, 1'b1, 1'b0, 1'b0, 0, 32'h0);         // ALU op
    issue(32'h104, 32'h0, 5'd11, 3'd3, 1'b1, 1'b1, 1'b0, 0, 32'h0);          // illegal funct3

    for (int n = 0; n < 150; n++) issue_random();

    // Reset in the 2nd WAIT cycle of a load
    ex_alu_result = 32'h300; ex_store_data = 32'h0; ex_rd = 5'd12; ex_funct3 = 3'd2;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_memtoreg = 1'b1;
    $display("txn: LW 0x300 rd=12, reset during WAIT");
    @(posedge clk);
    #1 dmem_ack = 1'b0;
    @(negedge clk);
    #3;
    chk("pre_rst_drain", 32'(ctl_q.size() + wb_q.size()), 32'd0);
    checking = 1'b0;
    ctl_q.delete();
    wb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("wait_dmem_req", 32'(dmem_req), 32'd1);
    chk("wait_mem_stall", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("midrst_mem_stall", 32'(mem_stall), 32'd0);
    chk("midrst_exmem_rd", 32'(exmem_rd), 32'd0);
    chk("midrst_exmem_rw", 32'(exmem_regwrite), 32'd0);
    chk("midrst_wb", {wb_wdata[26:0], wb_rd}, 32'd0);
    chk("midrst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("midrst_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    issue(32'h300, 32'h0, 5'd13, 3'd5, 1'b1, 1'b1, 1'b0, 1, 32'h0000F00D);   // LHU after reset
    for (int n = 0; n < 30; n++) issue_random();
    issue(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0);

    repeat (3) @(negedge clk);
    #3;
    chk("final_drain", 32'(ctl_q.size() + wb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the RV32I 5-stage pipeline. Sits directly downstream of ex_stage and upstream of write-back.
- Holds the EX/MEM and MEM/WB pipeline registers. Runs the data-memory req/ack handshake, with byte-lane strobes for stores and sign/zero extension for loads.
- Raises mem_stall while a memory access is pending. Supplies the EX/MEM and MEM/WB values that the forwarding unit uses.

Parameters:
- TIMEOUT, 16: maximum cycles dmem_req may stay high without dmem_ack before the access is aborted. Must be at least 2.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_alu_result  in  32  ALU result / effective address from ex_stage.
- ex_store_data  in  32  store data (rs2) from ex_stage.
- ex_rd  in  5  destination register.
- ex_funct3  in  3  load/store width and sign.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  in  1 each  control bits.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte enables (0 for loads).
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- exmem_alu_result  out  32  EX/MEM register value, for forwarding.
- exmem_rd  out  5  EX/MEM destination register.
- exmem_regwrite  out  1  EX/MEM regwrite.
- wb_wdata  out  32  MEM/WB write-back data.
- wb_rd  out  5  MEM/WB destination register.
- wb_regwrite  out  1  MEM/WB regwrite.
- mem_misalign  out  1  one-cycle pulse: misaligned address or illegal funct3.
- mem_timeout  out  1  one-cycle pulse: access aborted on timeout.

Behaviour:
- Reset (asynchronous, active-high): every register clears to 0 and the FSM goes to IDLE. All outputs are 0 during reset, including dmem_req, mem_stall and both pulses. Asserting reset mid-access drops dmem_req immediately and discards the access.
- EX/MEM register: loads all ex_* inputs on the rising edge when mem_stall=0, and holds them when mem_stall=1.
- Op decode (from the EX/MEM register):
  - store = memwrite; this takes priority if memread and memwrite are both set.
  - load = memread & !memwrite.
  - memop = load | store.
- Alignment check:
  - byte ops (funct3 000/100) are always aligned.
  - halfword ops (001/101) require addr[0]=0.
  - word ops (010) require addr[1:0]=0.
  - funct3 011/110/111 on a memop is illegal.
- Bad memop (misaligned or illegal):
  - no dmem_req is issued and no stall occurs.
  - mem_misalign pulses high for that cycle.
  - MEM/WB captures regwrite=0.
- FSM states and transitions:
  - IDLE → WAIT when a good memop is present and dmem_ack=0.
  - IDLE stays IDLE when dmem_ack=1 in the same cycle (zero-wait access).
  - WAIT → IDLE on dmem_ack.
  - WAIT → IDLE when the counter reaches TIMEOUT-1 with no ack.
- dmem_req = good memop & state in {IDLE, WAIT} & !rst. It is held continuously until ack or timeout. dmem_addr, dmem_we, dmem_wdata and dmem_wstrb stay stable while dmem_req is high.
- mem_stall = dmem_req & !dmem_ack & !timeout_hit. Minimum latency: zero stall cycles when dmem_ack arrives with dmem_req.
- Timeout:
  - the counter clears on entering WAIT and increments each WAIT cycle.
  - at TIMEOUT-1 without ack: mem_timeout pulses, dmem_req drops, stall releases, and MEM/WB captures regwrite=0.
- Store lanes, with o = addr[1:0]:
  - SB: wstrb = 0001<<o, wdata = {4{data[7:0]}}.
  - SH: wstrb = 0011<<(2*addr[1]), wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111, wdata = data.
- Load extraction: select the byte at o or the halfword at addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- MEM/WB register:
  - captures on every rising edge.
  - when mem_stall=1 it captures a bubble (wb_regwrite=0, wb_rd=0, wb_wdata=0).
  - otherwise it captures wb_wdata = memtoreg ? load_data : alu_result, together with rd and regwrite (regwrite cleared on bad memop or timeout).
- A store with regwrite=1 writes back alu_result. The write-back stage ignores rd=0.
- Non-memory instructions pass through in one cycle and never stall.

Decomposition:
- Shared package rv32i_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - FSM state encoding MEM_IDLE/MEM_WAIT.
- One natural sub-module, lsu_align (combinational): funct3 + addr + data → wstrb, wdata, load_data, misalign.

Test Plan:
- SW to 0x100 with data 0xDEADBEEF, ack on the same cycle → dmem_wstrb=1111, dmem_addr=0x100, no mem_stall, wb_regwrite=0.
- SB to 0x103 with data 0x000000AB → wstrb=1000, wdata=0xABABABAB. Then LB from 0x103 with rdata=0xAB000000 → wb_wdata=0xFFFFFFAB. LBU from the same address → wb_wdata=0x000000AB.
- LH from 0x102 with rdata=0x8001_0000, ack after 3 cycles → mem_stall high for exactly 3 cycles, 3 bubbles in MEM/WB, then wb_wdata=0xFFFF8001 and wb_rd correct.
- LW from 0x101 → no dmem_req, mem_misalign pulses for 1 cycle, wb_regwrite=0, no stall.
- LW with ack never asserted, TIMEOUT=16 → dmem_req high for 16 cycles, then a mem_timeout pulse, stall released, wb_regwrite=0.
- rst asserted in the 2nd WAIT cycle of a load → dmem_req, mem_stall and all wb_* outputs go to 0 immediately. After release the FSM is IDLE and the next instruction proceeds normally.
